// File: rtl/ama_riscv_bp_spec_tracker.sv
// Speculative branch tracker between decode and execute: a FIFO of predicted branches that feeds the predictor.
// Optional build macro BP_STATS_EN enables the saturating resolve/mispredict counters.
module ama_riscv_bp_spec_tracker #(
    parameter int DEPTH  = 4,
    parameter int ARCH_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              dec_br_i,
    input  logic [ARCH_W-1:0] dec_pc_i,
    input  logic [ARCH_W-1:0] dec_tgt_i,
    input  logic              dec_pred_i,
    input  logic              exe_res_v_i,
    input  logic              exe_taken_i,
    output logic              spec_enter_o,
    output logic              spec_resolve_o,
    output logic              br_res_o,
    output logic [ARCH_W-1:0] pc_exe_o,
    output logic              full_o,
    output logic              mispredict_o,
    output logic [ARCH_W-1:0] redirect_pc_o,
    output logic              err_underflow_o,
    output logic [31:0]       stat_resolved_o,
    output logic [31:0]       stat_mispred_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ARCH_W-1:0] pc_q  [DEPTH];
    logic [ARCH_W-1:0] tgt_q [DEPTH];
    logic [DEPTH-1:0]  pred_q;

    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic              empty;
    logic              resolve;
    logic              misp;
    logic              enter;
    logic              is_full;
    logic [ARCH_W-1:0] head_pc;
    logic [ARCH_W-1:0] head_tgt;
    logic              head_pred;

    // Everything toward the predictor is gated by reset so outputs drop to zero asynchronously.
    always_comb begin
        empty     = (cnt_q == '0);
        head_pc   = pc_q[rd_q];
        head_tgt  = tgt_q[rd_q];
        head_pred = pred_q[rd_q];
        resolve   = exe_res_v_i & ~empty & ~rst_i;
        misp      = resolve & (head_pred != exe_taken_i);
        is_full   = (cnt_q == DEPTH_C) & ~resolve;
        enter     = dec_br_i & ~is_full & ~misp & ~rst_i;
    end

    always_comb begin
        spec_enter_o    = enter;
        spec_resolve_o  = resolve;
        br_res_o        = resolve & exe_taken_i;
        mispredict_o    = misp;
        full_o          = is_full;
        err_underflow_o = err_q;
        pc_exe_o        = '0;
        redirect_pc_o   = '0;
        if (!empty && !rst_i) begin
            pc_exe_o      = head_pc;
            redirect_pc_o = exe_taken_i ? head_tgt : head_pc + ARCH_W'(4);
        end
    end

    // A mispredict squashes every younger entry, so the queue restarts just past the popped head.
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        err_d = err_q | (exe_res_v_i & empty);
        if (misp) begin
            rd_d  = rd_q + PTR_W'(1);
            wr_d  = rd_q + PTR_W'(1);
            cnt_d = '0;
        end else begin
            if (resolve) begin
                rd_d = rd_q + PTR_W'(1);
            end
            if (enter) begin
                wr_d = wr_q + PTR_W'(1);
            end
            if (enter && !resolve) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (!enter && resolve) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]  <= '0;
                tgt_q[i] <= '0;
            end
            pred_q <= '0;
        end else if (enter) begin
            pc_q[wr_q]   <= dec_pc_i;
            tgt_q[wr_q]  <= dec_tgt_i;
            pred_q[wr_q] <= dec_pred_i;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_res_q, stat_res_d;
    logic [31:0] stat_mis_q, stat_mis_d;

    // Counters stick at all-ones rather than wrapping back to zero.
    always_comb begin
        stat_res_d = stat_res_q;
        stat_mis_d = stat_mis_q;
        if (resolve && stat_res_q != 32'hFFFF_FFFF) begin
            stat_res_d = stat_res_q + 32'd1;
        end
        if (misp && stat_mis_q != 32'hFFFF_FFFF) begin
            stat_mis_d = stat_mis_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_res_q <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_res_q <= stat_res_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_resolved_o = stat_res_q;
    assign stat_mispred_o  = stat_mis_q;
`else
    assign stat_resolved_o = '0;
    assign stat_mispred_o  = '0;
`endif

endmodule

// File: tb/tb_ama_riscv_bp_spec_tracker.sv
// Self-checking bench for ama_riscv_bp_spec_tracker: queue-based reference model checked every
// negedge, plus directed scenarios with literal expectations.
module tb_ama_riscv_bp_spec_tracker;

    localparam int DEPTH  = 4;
    localparam int ARCH_W = 32;

    logic              clk;
    logic              rst;
    logic              decBr;
    logic [ARCH_W-1:0] decPc;
    logic [ARCH_W-1:0] decTgt;
    logic              decPred;
    logic              exeResV;
    logic              exeTaken;
    logic              specEnter;
    logic              specResolve;
    logic              brRes;
    logic [ARCH_W-1:0] pcExe;
    logic              full;
    logic              mispredict;
    logic [ARCH_W-1:0] redirectPc;
    logic              errUnderflow;
    logic [31:0]       statResolved;
    logic [31:0]       statMispred;

    int checks = 0;
    int errors = 0;

    ama_riscv_bp_spec_tracker #(.DEPTH(DEPTH), .ARCH_W(ARCH_W)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .dec_br_i        (decBr),
        .dec_pc_i        (decPc),
        .dec_tgt_i       (decTgt),
        .dec_pred_i      (decPred),
        .exe_res_v_i     (exeResV),
        .exe_taken_i     (exeTaken),
        .spec_enter_o    (specEnter),
        .spec_resolve_o  (specResolve),
        .br_res_o        (brRes),
        .pc_exe_o        (pcExe),
        .full_o          (full),
        .mispredict_o    (mispredict),
        .redirect_pc_o   (redirectPc),
        .err_underflow_o (errUnderflow),
        .stat_resolved_o (statResolved),
        .stat_mispred_o  (statMispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an in-order list of outstanding branches.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        pred;
    } entry_t;

    typedef struct {
        logic        enter;
        logic        resolve;
        logic        brRes;
        logic        misp;
        logic        full;
        logic [31:0] pcExe;
        logic [31:0] redirect;
    } exp_t;

    entry_t      mQueue[$];
    logic        mErr = 1'b0;
    logic [31:0] mResolved = '0;
    logic [31:0] mMispred = '0;

    function automatic exp_t modelEval();
        exp_t e;
        e.resolve  = !rst && exeResV && (mQueue.size() > 0);
        e.misp     = e.resolve && (mQueue[0].pred != exeTaken);
        e.full     = (mQueue.size() == DEPTH) && !e.resolve;
        e.enter    = !rst && decBr && !e.full && !e.misp;
        e.brRes    = e.resolve && exeTaken;
        e.pcExe    = 32'd0;
        e.redirect = 32'd0;
        if (!rst && mQueue.size() > 0) begin
            e.pcExe    = mQueue[0].pc;
            e.redirect = exeTaken ? mQueue[0].tgt : mQueue[0].pc + 32'd4;
        end
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        exp_t e;
        if (rst) begin
            mQueue.delete();
            mErr      = 1'b0;
            mResolved = '0;
            mMispred  = '0;
        end else begin
            e = modelEval();
            if (exeResV && mQueue.size() == 0) mErr = 1'b1;
            if (e.resolve && mResolved != 32'hFFFF_FFFF) mResolved = mResolved + 1;
            if (e.misp && mMispred != 32'hFFFF_FFFF) mMispred = mMispred + 1;
            if (e.misp) begin
                mQueue.delete();
            end else begin
                if (e.resolve) void'(mQueue.pop_front());
                if (e.enter) mQueue.push_back('{pc: decPc, tgt: decTgt, pred: decPred});
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        e = modelEval();
        checkOutput("m_spec_enter", {31'd0, specEnter}, {31'd0, e.enter});
        checkOutput("m_spec_resolve", {31'd0, specResolve}, {31'd0, e.resolve});
        checkOutput("m_br_res", {31'd0, brRes}, {31'd0, e.brRes});
        checkOutput("m_mispredict", {31'd0, mispredict}, {31'd0, e.misp});
        checkOutput("m_full", {31'd0, full}, {31'd0, e.full});
        checkOutput("m_pc_exe", pcExe, e.pcExe);
        checkOutput("m_redirect_pc", redirectPc, e.redirect);
        checkOutput("m_err_underflow", {31'd0, errUnderflow}, {31'd0, mErr});
`ifdef BP_STATS_EN
        checkOutput("m_stat_resolved", statResolved, mResolved);
        checkOutput("m_stat_mispred", statMispred, mMispred);
`else
        checkOutput("m_stat_resolved", statResolved, 32'd0);
        checkOutput("m_stat_mispred", statMispred, 32'd0);
`endif
    end

    task automatic applyStimulus(input logic br, input logic [31:0] pc, input logic [31:0] tgt,
                                 input logic pred, input logic resV, input logic taken);
        @(posedge clk);
        #1;
        decBr    = br;
        decPc    = pc;
        decTgt   = tgt;
        decPred  = pred;
        exeResV  = resV;
        exeTaken = taken;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resetDut();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        decBr    = 1'b0;
        exeResV  = 1'b0;
        exeTaken = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] drainPc[4];
        rst      = 1'b1;
        decBr    = 1'b0;
        decPc    = '0;
        decTgt   = '0;
        decPred  = 1'b0;
        exeResV  = 1'b0;
        exeTaken = 1'b0;
        #12;
        rst = 1'b0;

        $display("[TB] scenario 1: reset state and basic push/resolve");
        checkOutput("rst_pc_exe", pcExe, 32'd0);
        checkOutput("rst_full", {31'd0, full}, 32'd0);
        checkOutput("rst_err", {31'd0, errUnderflow}, 32'd0);
        applyStimulus(1'b1, 32'h100, 32'h140, 1'b1, 1'b0, 1'b0);
        checkOutput("s1_enter", {31'd0, specEnter}, 32'd1);
        checkOutput("s1_pc_exe_before", pcExe, 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("s1_resolve", {31'd0, specResolve}, 32'd1);
        checkOutput("s1_br_res", {31'd0, brRes}, 32'd1);
        checkOutput("s1_pc_exe", pcExe, 32'h100);
        checkOutput("s1_misp", {31'd0, mispredict}, 32'd0);
        checkOutput("s1_redirect", redirectPc, 32'h140);
        idle();
        checkOutput("s1_empty_pc", pcExe, 32'd0);

        $display("[TB] scenario 2: mispredict redirects");
        applyStimulus(1'b1, 32'h200, 32'h280, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("s2_misp_taken", {31'd0, mispredict}, 32'd1);
        checkOutput("s2_redirect_tgt", redirectPc, 32'h280);
        applyStimulus(1'b1, 32'h300, 32'h380, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("s2_misp_nt", {31'd0, mispredict}, 32'd1);
        checkOutput("s2_redirect_fall", redirectPc, 32'h304);
        checkOutput("s2_br_res_nt", {31'd0, brRes}, 32'd0);
        applyStimulus(1'b1, 32'hFFFF_FFFC, 32'h0000_1000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("s2_wrap_pc_exe", pcExe, 32'hFFFF_FFFC);
        checkOutput("s2_wrap_redirect", redirectPc, 32'd0);

        $display("[TB] scenario 3: full queue and push+pop while full");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'h400 + 32'(i * 16), 32'h480 + 32'(i * 16), 1'b1, 1'b0, 1'b0);
            checkOutput("s3_fill_enter", {31'd0, specEnter}, 32'd1);
        end
        applyStimulus(1'b1, 32'h440, 32'h4c0, 1'b1, 1'b0, 1'b0);
        checkOutput("s3_full", {31'd0, full}, 32'd1);
        checkOutput("s3_stall_enter", {31'd0, specEnter}, 32'd0);
        applyStimulus(1'b1, 32'h450, 32'h4d0, 1'b1, 1'b1, 1'b1);
        checkOutput("s3_full_freed", {31'd0, full}, 32'd0);
        checkOutput("s3_pushpop_enter", {31'd0, specEnter}, 32'd1);
        checkOutput("s3_pushpop_resolve", {31'd0, specResolve}, 32'd1);
        checkOutput("s3_pushpop_pc", pcExe, 32'h400);
        idle();
        checkOutput("s3_still_full", {31'd0, full}, 32'd1);
        drainPc[0] = 32'h410;
        drainPc[1] = 32'h420;
        drainPc[2] = 32'h430;
        drainPc[3] = 32'h450;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
            checkOutput("s3_drain_pc", pcExe, drainPc[i]);
        end
        idle();
        checkOutput("s3_drained", pcExe, 32'd0);

        $display("[TB] scenario 4: mispredict flushes younger entries and same-cycle push");
        applyStimulus(1'b1, 32'h10, 32'h18, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h20, 32'h28, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h30, 32'h38, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h40, 32'h48, 1'b1, 1'b1, 1'b0);
        checkOutput("s4_misp", {31'd0, mispredict}, 32'd1);
        checkOutput("s4_push_dropped", {31'd0, specEnter}, 32'd0);
        checkOutput("s4_redirect", redirectPc, 32'h14);
        idle();
        checkOutput("s4_flushed_pc", pcExe, 32'd0);
        applyStimulus(1'b1, 32'h50, 32'h58, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("s4_after_flush_pc", pcExe, 32'h50);
        checkOutput("s4_after_flush_misp", {31'd0, mispredict}, 32'd0);

        $display("[TB] scenario 5: underflow and async reset");
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("s5_no_resolve", {31'd0, specResolve}, 32'd0);
        checkOutput("s5_no_br_res", {31'd0, brRes}, 32'd0);
        idle();
        checkOutput("s5_err_set", {31'd0, errUnderflow}, 32'd1);
        idle();
        checkOutput("s5_err_held", {31'd0, errUnderflow}, 32'd1);
        applyStimulus(1'b1, 32'h600, 32'h680, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h610, 32'h690, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h620, 32'h6a0, 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("s5_rst_enter", {31'd0, specEnter}, 32'd0);
        checkOutput("s5_rst_resolve", {31'd0, specResolve}, 32'd0);
        checkOutput("s5_rst_pc_exe", pcExe, 32'd0);
        checkOutput("s5_rst_redirect", redirectPc, 32'd0);
        checkOutput("s5_rst_err", {31'd0, errUnderflow}, 32'd0);
        @(negedge clk);
        #1;
        decBr   = 1'b0;
        exeResV = 1'b0;
        rst     = 1'b0;
        applyStimulus(1'b1, 32'h700, 32'h780, 1'b1, 1'b0, 1'b0);
        checkOutput("s5_first_push", {31'd0, specEnter}, 32'd1);
        idle();
        checkOutput("s5_first_push_head", pcExe, 32'h700);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);

        $display("[TB] scenario 6: statistics counters");
        resetDut();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'h800 + 32'(i * 16), 32'h808 + 32'(i * 16), 1'b1, 1'b0, 1'b0);
            applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, (i == 2 || i == 5 || i == 8) ? 1'b0 : 1'b1);
        end
        idle();
`ifdef BP_STATS_EN
        checkOutput("s6_stat_resolved", statResolved, 32'd10);
        checkOutput("s6_stat_mispred", statMispred, 32'd3);
`else
        checkOutput("s6_stat_resolved", statResolved, 32'd0);
        checkOutput("s6_stat_mispred", statMispred, 32'd0);
`endif
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
